switch_allocator: RTL

Packet-level (wormhole) switch allocator that drives the control side of the router's round-robin crossbar. Per output port it holds a lock from a packet's head flit to its tail flit. It arbitrates contending head flits with a per-output round-robin pointer. It produces the per-input dest/dest_en vector the crossbar consumes and a per-input grant that pops the input buffer. Because the allocator already guarantees at most one enabled input per output, the crossbar's own per-cycle rotation never drops a granted flit.

---
 rtl/switch_allocator.sv | 123 ++++++++++++
 1 files changed

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output head-to-tail locks, round-robin arbitration
// between contending heads, and the crossbar dest/dest_en control vector.
module switch_allocator #(
   parameter int  PORTS = 2,
   localparam int DW    = $clog2(PORTS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid [PORTS],
   input  logic [DW-1:0] req_dest  [PORTS],
   input  logic          req_head  [PORTS],
   input  logic          req_tail  [PORTS],
   input  logic          out_ready [PORTS],
   output logic          grant     [PORTS],
   output logic [DW-1:0] dest      [PORTS],
   output logic          dest_en   [PORTS],
   output logic          locked    [PORTS],
   output logic [DW-1:0] owner     [PORTS],
   output logic          err
);

   localparam int SW = DW + 1;

   typedef enum logic {S_IDLE, S_LOCKED} out_state_t;

   out_state_t    state    [PORTS];
   logic [DW-1:0] rr_ptr   [PORTS];
   logic [DW-1:0] owner_q  [PORTS];
   logic          out_gnt  [PORTS];
   logic [DW-1:0] out_win  [PORTS];
   logic          err_now;

   // Handshake: grant[i] is asserted in the same cycle input i presents a flit
   // that is transferred; upstream pops its buffer on grant, downstream sees
   // the flit because out_ready was high for the chosen output.
   always_comb begin
      logic          found;
      logic [SW-1:0] sum;
      logic [DW-1:0] idx;
      found   = 1'b0;
      sum     = '0;
      idx     = '0;
      err_now = 1'b0;
      for (int o = 0; o < PORTS; o++) begin
         out_gnt[o] = 1'b0;
         out_win[o] = '0;
         if (state[o] == S_LOCKED) begin
            out_win[o] = owner_q[o];
            for (int i = 0; i < PORTS; i++) begin
               if (owner_q[o] == DW'(i) && req_valid[i] && req_dest[i] == DW'(o) &&
                   !req_head[i] && out_ready[o])
                  out_gnt[o] = 1'b1;
            end
         end else begin
            found = 1'b0;
            // Scan from rr_ptr upward, wrapping by subtraction so any PORTS works
            for (int k = 0; k < PORTS; k++) begin
               sum = {1'b0, rr_ptr[o]} + SW'(k);
               if (sum >= SW'(PORTS)) sum = sum - SW'(PORTS);
               idx = sum[DW-1:0];
               if (!found && req_valid[idx] && req_head[idx] && req_dest[idx] == DW'(o)) begin
                  found      = 1'b1;
                  out_win[o] = idx;
               end
            end
            out_gnt[o] = found && out_ready[o];
         end
      end
      for (int i = 0; i < PORTS; i++) begin
         for (int o = 0; o < PORTS; o++) begin
            if (req_valid[i] && req_dest[i] == DW'(o)) begin
               if (!req_head[i] && (state[o] != S_LOCKED || owner_q[o] != DW'(i)))
                  err_now = 1'b1;
               if (req_head[i] && state[o] == S_LOCKED && owner_q[o] == DW'(i))
                  err_now = 1'b1;
            end
         end
      end
      for (int i = 0; i < PORTS; i++) begin
         grant[i] = 1'b0;
         for (int o = 0; o < PORTS; o++) begin
            if (out_gnt[o] && out_win[o] == DW'(i) && !rst) grant[i] = 1'b1;
         end
         dest[i]    = req_dest[i];
         dest_en[i] = grant[i];
      end
   end

   always_comb begin
      for (int o = 0; o < PORTS; o++) begin
         locked[o] = (state[o] == S_LOCKED);
         owner[o]  = owner_q[o];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
         for (int o = 0; o < PORTS; o++) begin
            state[o]   <= S_IDLE;
            rr_ptr[o]  <= '0;
            owner_q[o] <= '0;
         end
      end else begin
         err <= err | err_now;
         for (int o = 0; o < PORTS; o++) begin
            if (out_gnt[o]) begin
               if (state[o] == S_IDLE) begin
                  if (out_win[o] == DW'(PORTS - 1)) rr_ptr[o] <= '0;
                  else                              rr_ptr[o] <= out_win[o] + 1'b1;
                  if (!req_tail[out_win[o]]) begin
                     state[o]   <= S_LOCKED;
                     owner_q[o] <= out_win[o];
                  end
               end else if (req_tail[out_win[o]]) begin
                  state[o] <= S_IDLE;
               end
            end
         end
      end
   end

endmodule
